// File: rtl/apa102_in_pkg.sv
// APA102 protocol constants, receiver states and LED frame layout shared by the apa102_in files.
package apa102_in_pkg;

    localparam int unsigned FRAME_BITS       = 32;
    localparam int unsigned START_FRAME_BITS = 32;
    localparam int unsigned BIT_CNT_W        = 5;
    localparam int unsigned PIXEL_WORD_W     = 16;
    localparam int unsigned ERR_CNT_W        = 8;

    localparam logic [2:0]            LED_HEADER = 3'b111;
    localparam logic [FRAME_BITS-1:0] END_FRAME  = 32'hFFFF_FFFF;

    localparam logic [BIT_CNT_W-1:0] LAST_FRAME_BIT = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_START_BIT = BIT_CNT_W'(START_FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LED   = 2'd2
    } state_t;

    // LED frame as it appears on the wire, MSB first
    typedef struct packed {
        logic [2:0] header;
        logic [4:0] bright;
        logic [7:0] blue;
        logic [7:0] green;
        logic [7:0] red;
    } led_frame_t;

endpackage

// File: rtl/apa102_in_sync_edge.sv
// Two-flop synchronizer with rising-edge detect for an asynchronous input pin.
module apa102_in_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/apa102_in.sv
// APA102 two-wire receiver: decodes start/LED/end frames and writes each pixel as two SRAM words.
// Define APA102_IN_ERROR_COUNT_EN to add a saturating error_count output (framing errors + timeouts).
module apa102_in
    import apa102_in_pkg::*;
#(
    parameter int unsigned ADDRESS_BUS_WIDTH = 16,
    parameter int unsigned DATA_BUS_WIDTH    = 16,
    parameter int unsigned TIMEOUT_BITS      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
    input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
    input  logic [TIMEOUT_BITS-1:0]      timeout,
    input  logic                         data_in,
    input  logic                         clock_in,
    output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
    output logic [DATA_BUS_WIDTH-1:0]    write_data,
    output logic                         write_strobe,
    output logic                         frame_done,
    output logic [ADDRESS_BUS_WIDTH-1:0] pixel_count
`ifdef APA102_IN_ERROR_COUNT_EN
    ,
    output logic [ERR_CNT_W-1:0]         error_count
`endif
);

    localparam int unsigned AW = ADDRESS_BUS_WIDTH;
    localparam int unsigned DW = DATA_BUS_WIDTH;
    localparam int unsigned TW = TIMEOUT_BITS;
    localparam int unsigned IW = ADDRESS_BUS_WIDTH + 1;

    logic                  sample_c;
    logic                  data_meta_q;
    logic                  data_sync_q;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  frame_rdy_q, frame_rdy_d;
    logic                  w1_pend_q, w1_pend_d;
    logic [PIXEL_WORD_W-1:0] w1_data_q, w1_data_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         cfg_start_q, cfg_start_d;
    logic [AW-1:0]         cfg_count_q, cfg_count_d;
    logic [TW-1:0]         cfg_timeout_q, cfg_timeout_d;
    logic [TW-1:0]         idle_q, idle_d;

    logic [AW-1:0]         addr_d;
    logic [DW-1:0]         data_d;
    logic                  strobe_d;
    logic                  done_d;
    logic [AW-1:0]         pix_d;

    led_frame_t            frame_c;
    logic                  idx_in_range_c;
    logic [IW-1:0]         idx_next_c;
    logic [AW-1:0]         word_addr_c;
    logic                  timed_out_c;
    logic                  err_inc_c;

    apa102_in_sync_edge u_clock_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (clock_in),
        .rise_c   (sample_c)
    );

    assign frame_c        = led_frame_t'(shift_q);
    // The index saturates past the address range, so it stays out of range for any word_count
    assign idx_in_range_c = idx_q < IW'(cfg_count_q);
    assign idx_next_c     = idx_q[AW] ? idx_q : idx_q + IW'(1);
    assign word_addr_c    = cfg_start_q + idx_q[AW-1:0];
    assign timed_out_c    = (state_q != ST_HUNT) && (cfg_timeout_q != '0)
                            && (idle_q >= cfg_timeout_q);

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        frame_rdy_d   = 1'b0;
        w1_pend_d     = 1'b0;
        w1_data_d     = w1_data_q;
        idx_d         = idx_q;
        cfg_start_d   = cfg_start_q;
        cfg_count_d   = cfg_count_q;
        cfg_timeout_d = cfg_timeout_q;
        idle_d        = idle_q;
        addr_d        = write_address;
        data_d        = write_data;
        strobe_d      = 1'b0;
        done_d        = 1'b0;
        pix_d         = pixel_count;
        err_inc_c     = 1'b0;

        if (sample_c || state_q == ST_HUNT) begin
            idle_d = '0;
        end else if (idle_q != '1) begin
            idle_d = idle_q + TW'(1);
        end

        // Second word of the previous pixel completes even if the receiver is being disabled
        if (w1_pend_q) begin
            if (idx_in_range_c) begin
                strobe_d = 1'b1;
                addr_d   = word_addr_c;
                data_d   = DW'(w1_data_q);
            end
            idx_d = idx_next_c;
        end

        if (!enable) begin
            state_d   = ST_HUNT;
            bit_cnt_d = '0;
        end else if (frame_rdy_q) begin
            if (shift_q == END_FRAME) begin
                done_d  = 1'b1;
                state_d = ST_HUNT;
            end else if (frame_c.header != LED_HEADER) begin
                err_inc_c = 1'b1;
                state_d   = ST_HUNT;
            end else begin
                pix_d = pixel_count + AW'(1);
                if (idx_in_range_c) begin
                    strobe_d = 1'b1;
                    addr_d   = word_addr_c;
                    data_d   = DW'({3'b000, frame_c.bright, frame_c.blue});
                end
                idx_d     = idx_next_c;
                w1_pend_d = 1'b1;
                w1_data_d = {frame_c.green, frame_c.red};
            end
        end else if (sample_c) begin
            shift_d = {shift_q[FRAME_BITS-2:0], data_sync_q};
            unique case (state_q)
                ST_HUNT: begin
                    if (data_sync_q) begin
                        bit_cnt_d = '0;
                    end else if (bit_cnt_q == LAST_START_BIT) begin
                        state_d       = ST_ARMED;
                        bit_cnt_d     = '0;
                        pix_d         = '0;
                        idx_d         = '0;
                        cfg_start_d   = start_address;
                        cfg_count_d   = word_count;
                        cfg_timeout_d = timeout;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
                ST_ARMED: begin
                    if (data_sync_q) begin
                        state_d   = ST_LED;
                        bit_cnt_d = BIT_CNT_W'(1);
                    end
                end
                ST_LED: begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == LAST_FRAME_BIT) begin
                        frame_rdy_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_HUNT;
                    bit_cnt_d = '0;
                end
            endcase
        end else if (timed_out_c) begin
            err_inc_c = 1'b1;
            state_d   = ST_HUNT;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_meta_q   <= 1'b0;
            data_sync_q   <= 1'b0;
            state_q       <= ST_HUNT;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            frame_rdy_q   <= 1'b0;
            w1_pend_q     <= 1'b0;
            w1_data_q     <= '0;
            idx_q         <= '0;
            cfg_start_q   <= '0;
            cfg_count_q   <= '0;
            cfg_timeout_q <= '0;
            idle_q        <= '0;
            write_address <= '0;
            write_data    <= '0;
            write_strobe  <= 1'b0;
            frame_done    <= 1'b0;
            pixel_count   <= '0;
        end else begin
            data_meta_q   <= data_in;
            data_sync_q   <= data_meta_q;
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_rdy_q   <= frame_rdy_d;
            w1_pend_q     <= w1_pend_d;
            w1_data_q     <= w1_data_d;
            idx_q         <= idx_d;
            cfg_start_q   <= cfg_start_d;
            cfg_count_q   <= cfg_count_d;
            cfg_timeout_q <= cfg_timeout_d;
            idle_q        <= idle_d;
            write_address <= addr_d;
            write_data    <= data_d;
            write_strobe  <= strobe_d;
            frame_done    <= done_d;
            pixel_count   <= pix_d;
        end
    end

`ifdef APA102_IN_ERROR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_inc_c && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign error_count = err_cnt_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc_c;
`endif

endmodule
